// File: rtl/sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage: pairs x[k] with x[k+H] through an H-deep delay memory.
// Optional build macro SDF_BFLY_ROUND_EN selects round-half-up scaling with positive saturation.
module sdf_butterfly #(
    parameter int DBW = 8,
    parameter int CBW = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [2*DBW-1:0] din,
    output logic [2*DBW-1:0] dout,
    output logic             dout_valid,
    output logic             dout_first
);

    localparam int H = 2 ** (CBW - 1);

    logic [CBW-1:0]   cnt;
    logic             primed;
    logic [2*DBW-1:0] mem [H];

    logic [CBW-2:0]   idx;
    logic             phase_b;
    logic [2*DBW-1:0] mem_rd;

    logic signed [DBW:0] a_re, a_im, b_re, b_im;
    logic [2*DBW-1:0]    sum_out, dif_out;

    assign idx     = cnt[CBW-2:0];
    assign phase_b = cnt[CBW-1];
    assign mem_rd  = mem[idx];

    assign a_re = {mem_rd[2*DBW-1], mem_rd[2*DBW-1:DBW]};
    assign a_im = {mem_rd[DBW-1],   mem_rd[DBW-1:0]};
    assign b_re = {din[2*DBW-1],    din[2*DBW-1:DBW]};
    assign b_im = {din[DBW-1],      din[DBW-1:0]};

`ifdef SDF_BFLY_ROUND_EN
    localparam logic signed [DBW+1:0] MAX_POS = (2 ** (DBW - 1)) - 1;

    // Round half up in DBW+2 bits; only the positive side can exceed DBW bits.
    function automatic logic [DBW-1:0] scale(input logic signed [DBW:0] v);
        logic signed [DBW+1:0] w;
        w = {v[DBW], v} + {{(DBW+1){1'b0}}, 1'b1};
        w = w >>> 1;
        return (w > MAX_POS) ? MAX_POS[DBW-1:0] : DBW'(w);
    endfunction
`else
    function automatic logic [DBW-1:0] scale(input logic signed [DBW:0] v);
        return DBW'(v >>> 1);
    endfunction
`endif

    always_comb begin
        sum_out = {scale(a_re + b_re), scale(a_im + b_im)};
        dif_out = {scale(a_re - b_re), scale(a_im - b_im)};
    end

    // The delay line holds raw x[k] in phase A and the pending difference in phase B.
    always_ff @(posedge clk) begin
        if (!clear) begin
            mem[idx] <= phase_b ? dif_out : din;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt        <= '0;
            primed     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
        end else begin
            cnt <= cnt + CBW'(1);
            if (&cnt) begin
                primed <= 1'b1;
            end
            if (phase_b) begin
                dout       <= sum_out;
                dout_valid <= 1'b1;
                dout_first <= (idx == '0);
            end else begin
                dout       <= primed ? mem_rd : '0;
                dout_first <= 1'b0;
            end
        end
    end

endmodule
